ddr3_timing_checker: RTL and testbench

//  Protocol-side counterpart of the controller's delay counters: monitors the DDR3 command bus
//  as seen by the memory model and flags every command that breaks a JEDEC timing or bank-state rule.

---
 rtl/ddr3_chk_pkg.sv | 21 ++
 rtl/ddr3_bank_timer.sv | 63 ++++++
 rtl/ddr3_timing_checker.sv | 103 ++++++++++
 tb/tb_ddr3_timing_checker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ddr3_chk_pkg.sv
// Shared command/violation encodings and timing defaults for the DDR3 command-bus timing checker.
package ddr3_chk_pkg;

  typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE, PREA, REF, MRS} cmd_e;

  typedef enum logic [3:0] {
    VIOL_NONE, VIOL_ACT_OPEN, VIOL_BANK_IDLE, VIOL_REF_OPEN, VIOL_TRFC,
    VIOL_TRP, VIOL_TRCD, VIOL_TRAS, VIOL_TWR, VIOL_TCCD
  } viol_e;

  typedef enum logic {BANK_IDLE, BANK_ACTIVE} bank_state_e;

  localparam int DEF_NBANKS = 8;
  localparam int DEF_CNT_W  = 8;

  // Minimum WR->PRE distance: write data burst must land, then recovery time.
  function automatic int wr_recovery(input int cwl, input int bl, input int t_wr);
    return cwl + bl / 2 + t_wr;
  endfunction

endpackage

// File: rtl/ddr3_bank_timer.sv
// One bank's open/closed state and elapsed-cycle counters, plus the bank-local rule fail flags.
module ddr3_bank_timer
  import ddr3_chk_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_RCD    = 5,
  parameter int T_RP     = 5,
  parameter int T_RAS    = 15,
  parameter int T_WR_MIN = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        chk,
  input  cmd_e        cmd,
  input  logic        sel,
  output bank_state_e state,
  output logic        f_act_open,
  output logic        f_bank_idle,
  output logic        f_trp,
  output logic        f_trcd,
  output logic        f_tras,
  output logic        f_twr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] since_act, since_pre, since_wr;
  logic hit_act, hit_col, hit_wr, hit_pre, is_active;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign is_active = (state == BANK_ACTIVE);
  assign hit_act   = chk && sel && (cmd == ACT);
  assign hit_col   = chk && sel && (cmd == RD || cmd == WR);
  assign hit_wr    = chk && sel && (cmd == WR);
  assign hit_pre   = chk && ((sel && cmd == PRE) || cmd == PREA);

  // Precharge of an already idle bank is harmless, so tRAS/tWR only apply to open banks.
  assign f_act_open  = hit_act && is_active;
  assign f_bank_idle = hit_col && !is_active;
  assign f_trp       = hit_act && (since_pre < CNT_W'(T_RP));
  assign f_trcd      = hit_col && (since_act < CNT_W'(T_RCD));
  assign f_tras      = hit_pre && is_active && (since_act < CNT_W'(T_RAS));
  assign f_twr       = hit_pre && is_active && (since_wr < CNT_W'(T_WR_MIN));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= BANK_IDLE;
      since_act <= CNT_MAX;
      since_pre <= CNT_MAX;
      since_wr  <= CNT_MAX;
    end else begin
      since_act <= hit_act ? CNT_W'(1) : sat_inc(since_act);
      since_pre <= hit_pre ? CNT_W'(1) : sat_inc(since_pre);
      since_wr  <= hit_wr  ? CNT_W'(1) : sat_inc(since_wr);
      if (hit_act)      state <= BANK_ACTIVE;
      else if (hit_pre) state <= BANK_IDLE;
    end
  end

endmodule

// File: rtl/ddr3_timing_checker.sv
// Passive DDR3 command-bus monitor: flags timing and bank-state rule breaks one cycle after the command.
module ddr3_timing_checker
  import ddr3_chk_pkg::*;
#(
  parameter int NBANKS = DEF_NBANKS,
  parameter int T_RCD  = 5,
  parameter int T_RP   = 5,
  parameter int T_RAS  = 15,
  parameter int T_RFC  = 44,
  parameter int T_CCD  = 4,
  parameter int T_WR   = 6,
  parameter int CWL    = 5,
  parameter int BL     = 8,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int BW    = $clog2(NBANKS)
) (
  input  logic          clock,
  input  logic          reset,
  // cmd_valid qualifies cmd/bank for one cycle; there is no ready, the checker never stalls the bus.
  input  logic          cmd_valid,
  input  cmd_e          cmd,
  input  logic [BW-1:0] bank,
  output logic          violation,
  output viol_e         viol_code,
  output logic [BW-1:0] viol_bank,
  output logic [15:0]   viol_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NBANKS-1:0] f_act_open, f_bank_idle, f_trp, f_trcd, f_tras, f_twr, active;
  bank_state_e       bank_state [NBANKS];
  logic [CNT_W-1:0]  since_ref, since_col;
  logic              chk, is_col, banked, ref_open, trfc, tccd;
  logic [BW-1:0]     cmd_bank, bank_next;
  viol_e             code_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [BW-1:0] lowest(input logic [NBANKS-1:0] v);
    lowest = '0;
    for (int i = NBANKS - 1; i >= 0; i--) if (v[i]) lowest = BW'(i);
  endfunction

  assign chk      = cmd_valid && (cmd != NOP);
  assign is_col   = (cmd == RD) || (cmd == WR);
  assign banked   = (cmd == ACT) || is_col || (cmd == PRE);
  assign cmd_bank = banked ? bank : '0;
  assign ref_open = chk && (cmd == REF || cmd == MRS) && (|active);
  assign trfc     = chk && (since_ref < CNT_W'(T_RFC));
  assign tccd     = chk && is_col && (since_col < CNT_W'(T_CCD));

  for (genvar i = 0; i < NBANKS; i++) begin : g_bank
    assign active[i] = (bank_state[i] == BANK_ACTIVE);
    ddr3_bank_timer #(
      .CNT_W(CNT_W), .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
      .T_WR_MIN(wr_recovery(CWL, BL, T_WR))
    ) u_timer (
      .clock(clock), .reset(reset), .chk(chk), .cmd(cmd), .sel(bank == BW'(i)),
      .state(bank_state[i]),
      .f_act_open(f_act_open[i]), .f_bank_idle(f_bank_idle[i]), .f_trp(f_trp[i]),
      .f_trcd(f_trcd[i]), .f_tras(f_tras[i]), .f_twr(f_twr[i])
    );
  end

  // Only the highest-priority rule is reported; for PREA the lowest failing bank wins.
  always_comb begin
    code_next = VIOL_NONE;
    bank_next = '0;
    if (|f_act_open)       begin code_next = VIOL_ACT_OPEN;  bank_next = lowest(f_act_open);  end
    else if (|f_bank_idle) begin code_next = VIOL_BANK_IDLE; bank_next = lowest(f_bank_idle); end
    else if (ref_open)     begin code_next = VIOL_REF_OPEN;  bank_next = cmd_bank;            end
    else if (trfc)         begin code_next = VIOL_TRFC;      bank_next = cmd_bank;            end
    else if (|f_trp)       begin code_next = VIOL_TRP;       bank_next = lowest(f_trp);       end
    else if (|f_trcd)      begin code_next = VIOL_TRCD;      bank_next = lowest(f_trcd);      end
    else if (|f_tras)      begin code_next = VIOL_TRAS;      bank_next = lowest(f_tras);      end
    else if (|f_twr)       begin code_next = VIOL_TWR;       bank_next = lowest(f_twr);       end
    else if (tccd)         begin code_next = VIOL_TCCD;      bank_next = cmd_bank;            end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      violation  <= 1'b0;
      viol_code  <= VIOL_NONE;
      viol_bank  <= '0;
      viol_count <= '0;
      since_ref  <= CNT_MAX;
      since_col  <= CNT_MAX;
    end else begin
      since_ref <= (chk && cmd == REF) ? CNT_W'(1) : sat_inc(since_ref);
      since_col <= (chk && is_col)     ? CNT_W'(1) : sat_inc(since_col);
      violation <= (code_next != VIOL_NONE);
      if (code_next != VIOL_NONE) begin
        viol_code <= code_next;
        viol_bank <= bank_next;
        if (viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ddr3_timing_checker.sv
// Directed bench for ddr3_timing_checker: linear command sequence with hand-computed expectations.
module tb_ddr3_timing_checker;
  import ddr3_chk_pkg::*;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  cmd_e        cmd;
  logic [2:0]  bank;
  logic        violation;
  viol_e       viol_code;
  logic [2:0]  viol_bank;
  logic [15:0] viol_count;

  int vectors;
  int miscompares;

  ddr3_timing_checker dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .bank(bank),
    .violation(violation), .viol_code(viol_code), .viol_bank(viol_bank), .viol_count(viol_count)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // driver tasks: inputs change 1ns after the edge, outputs are sampled 1ns after the next edge
  task automatic step(input logic v, input cmd_e c, input logic [2:0] b);
    cmd_valid = v;
    cmd       = c;
    bank      = b;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input cmd_e c, input logic [2:0] b);
    step(1'b1, c, b);
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'b0, NOP, 3'd0);
  endtask

  task automatic check(input string tag, input logic ev, input viol_e ec,
                       input logic [2:0] eb, input logic [15:0] en);
    vectors++;
    assert (violation === ev) else begin
      miscompares++;
      $error("FAIL %s violation got %b exp %b", tag, violation, ev);
    end
    vectors++;
    assert (viol_code === ec) else begin
      miscompares++;
      $error("FAIL %s viol_code got %0d exp %0d", tag, viol_code, ec);
    end
    vectors++;
    assert (viol_bank === eb) else begin
      miscompares++;
      $error("FAIL %s viol_bank got %0d exp %0d", tag, viol_bank, eb);
    end
    vectors++;
    assert (viol_count === en) else begin
      miscompares++;
      $error("FAIL %s viol_count got %0d exp %0d", tag, viol_count, en);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd         = NOP;
    bank        = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    check("reset", 1'b0, VIOL_NONE, 3'd0, 16'd0);
    reset = 1'b1;

    // 1: tRCD
    issue(ACT, 3'd0);                 check("act_b0", 1'b0, VIOL_NONE, 3'd0, 16'd0);
    step(1'b0, ACT, 3'd0);            check("invalid_act", 1'b0, VIOL_NONE, 3'd0, 16'd0);
    gap(3);
    issue(RD, 3'd0);                  check("rd_trcd_ok", 1'b0, VIOL_NONE, 3'd0, 16'd0);
    gap(9);
    issue(PRE, 3'd0);                 check("pre_tras_ok", 1'b0, VIOL_NONE, 3'd0, 16'd0);
    gap(4);
    issue(ACT, 3'd0);                 check("act_trp_ok", 1'b0, VIOL_NONE, 3'd0, 16'd0);
    gap(3);
    issue(RD, 3'd0);                  check("rd_trcd_bad", 1'b1, VIOL_TRCD, 3'd0, 16'd1);
    issue(NOP, 3'd0);                 check("pulse_end", 1'b0, VIOL_TRCD, 3'd0, 16'd1);

    // 2: tRAS then tRP
    issue(ACT, 3'd2);                 check("act_b2", 1'b0, VIOL_TRCD, 3'd0, 16'd1);
    gap(13);
    issue(PRE, 3'd2);                 check("pre_tras_bad", 1'b1, VIOL_TRAS, 3'd2, 16'd2);
    gap(3);
    issue(ACT, 3'd2);                 check("act_trp_bad", 1'b1, VIOL_TRP, 3'd2, 16'd3);

    // 3: write recovery
    issue(ACT, 3'd1);                 check("act_b1", 1'b0, VIOL_TRP, 3'd2, 16'd3);
    gap(4);
    issue(WR, 3'd1);                  check("wr_b1", 1'b0, VIOL_TRP, 3'd2, 16'd3);
    gap(13);
    issue(PRE, 3'd1);                 check("pre_twr_bad", 1'b1, VIOL_TWR, 3'd1, 16'd4);
    gap(4);
    issue(ACT, 3'd1);
    gap(4);
    issue(WR, 3'd1);
    gap(14);
    issue(PRE, 3'd1);                 check("pre_twr_ok", 1'b0, VIOL_TWR, 3'd1, 16'd4);

    // 4: refresh rules (b0 and b2 still open)
    issue(ACT, 3'd3);                 check("act_b3", 1'b0, VIOL_TWR, 3'd1, 16'd4);
    issue(REF, 3'd5);                 check("ref_open", 1'b1, VIOL_REF_OPEN, 3'd0, 16'd5);
    gap(43);
    issue(PREA, 3'd0);                check("prea_ok", 1'b0, VIOL_REF_OPEN, 3'd0, 16'd5);
    issue(REF, 3'd0);                 check("ref_idle_ok", 1'b0, VIOL_REF_OPEN, 3'd0, 16'd5);
    gap(42);
    issue(ACT, 3'd0);                 check("act_trfc_bad", 1'b1, VIOL_TRFC, 3'd0, 16'd6);
    issue(ACT, 3'd1);                 check("act_trfc_ok", 1'b0, VIOL_TRFC, 3'd0, 16'd6);

    // 5: idle-bank read, TRCD outranks TCCD
    issue(RD, 3'd4);                  check("rd_idle", 1'b1, VIOL_BANK_IDLE, 3'd4, 16'd7);
    issue(ACT, 3'd7);                 check("act_b7", 1'b0, VIOL_BANK_IDLE, 3'd4, 16'd7);
    gap(3);
    issue(ACT, 3'd6);
    issue(RD, 3'd7);                  check("rd_b7_ok", 1'b0, VIOL_BANK_IDLE, 3'd4, 16'd7);
    gap(1);
    issue(RD, 3'd6);                  check("trcd_over_tccd", 1'b1, VIOL_TRCD, 3'd6, 16'd8);
    issue(NOP, 3'd0);                 check("single_count", 1'b0, VIOL_TRCD, 3'd6, 16'd8);
    issue(PREA, 3'd3);                check("prea_lowest", 1'b1, VIOL_TRAS, 3'd0, 16'd9);

    // 6: async reset, then counter saturation
    gap(4);
    issue(ACT, 3'd5);                 check("act_b5", 1'b0, VIOL_TRAS, 3'd0, 16'd9);
    #2 reset = 1'b0;
    #1 check("async_reset", 1'b0, VIOL_NONE, 3'd0, 16'd0);
    @(posedge clock);
    #1 check("reset_held", 1'b0, VIOL_NONE, 3'd0, 16'd0);
    reset = 1'b1;
    issue(RD, 3'd5);                  check("rd_after_reset", 1'b1, VIOL_BANK_IDLE, 3'd5, 16'd1);
    repeat (65534) issue(RD, 3'd5);
    check("count_max", 1'b1, VIOL_BANK_IDLE, 3'd5, 16'hFFFF);
    repeat (3) issue(RD, 3'd5);
    check("count_sat", 1'b1, VIOL_BANK_IDLE, 3'd5, 16'hFFFF);
    gap(1);
    check("count_hold", 1'b0, VIOL_BANK_IDLE, 3'd5, 16'hFFFF);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
